// File: rtl/line_buffer3.sv
// line_buffer3 -- raster-to-column converter for a 3x3 convolution window.
//
// Accepts one pixel per cycle in row-major order and keeps the two previous
// rows in line memories. For every accepted pixel it presents three vertically
// aligned pixels (rows r-2, r-1, r) with a shift enable for the downstream
// window shift register.
//
// Ports:
//   clk, rst           single rising-edge clock, synchronous active-high reset
//   pix_valid          pix_in carries a pixel this cycle (no backpressure)
//   pix_sof            start of frame, qualified by pix_valid
//   pix_in             input pixel
//   out_l1/l2/l3       pixels from rows r-2, r-1, r at the same column
//   wr_sft_en          window shift enable (pix_valid delayed one cycle)
//   win_valid          after this shift the 3x3 window is complete
//   col_cnt/row_cnt    position of the pixel on out_l3
//   frame_done         pulse with the last pixel of a frame
//
// Build option: define LB_ZERO_PAD_EN to force out_l1 to zero in rows 0 and 1
// and out_l2 to zero in row 0 (zero top padding).
module line_buffer3 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [DATA_W-1:0] pix_in,
    output logic [DATA_W-1:0] out_l1,
    output logic [DATA_W-1:0] out_l2,
    output logic [DATA_W-1:0] out_l3,
    output logic              wr_sft_en,
    output logic              win_valid,
    output logic [CNT_W-1:0]  col_cnt,
    output logic [CNT_W-1:0]  row_cnt,
    output logic              frame_done
);

    localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CNT_W-1:0] ColLast = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] RowLast = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] Two     = CNT_W'(2);

    // Line memories: mem_a holds row r-1, mem_b holds row r-2. Not reset.
    logic [DATA_W-1:0] mem_a_q [IMG_W];
    logic [DATA_W-1:0] mem_b_q [IMG_W];

    logic [CNT_W-1:0]  icol_q, icol_d, irow_q, irow_d;
    logic [CNT_W-1:0]  cur_col, cur_row;
    logic [AW-1:0]     col_idx;
    logic [DATA_W-1:0] rd_a, rd_b;

    logic [DATA_W-1:0] out_l1_q, out_l1_d, out_l2_q, out_l2_d, out_l3_q, out_l3_d;
    logic              wr_sft_en_q, wr_sft_en_d, win_valid_q, win_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;

    // A start-of-frame pixel is (0,0) no matter where the counters were.
    always_comb begin
        cur_col = (pix_valid && pix_sof) ? '0 : icol_q;
        cur_row = (pix_valid && pix_sof) ? '0 : irow_q;
    end

    assign col_idx = cur_col[AW-1:0];
    assign rd_a    = mem_a_q[col_idx];
    assign rd_b    = mem_b_q[col_idx];

    always_comb begin
        icol_d       = icol_q;
        irow_d       = irow_q;
        out_l1_d     = out_l1_q;
        out_l2_d     = out_l2_q;
        out_l3_d     = out_l3_q;
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        wr_sft_en_d  = 1'b0;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (pix_valid) begin
            if (cur_col == ColLast) begin
                icol_d = '0;
                irow_d = (cur_row == RowLast) ? '0 : cur_row + 1'b1;
            end else begin
                icol_d = cur_col + 1'b1;
                irow_d = cur_row;
            end

`ifdef LB_ZERO_PAD_EN
            out_l1_d = (cur_row < Two) ? '0 : rd_b;
            out_l2_d = (cur_row == '0) ? '0 : rd_a;
`else
            out_l1_d = rd_b;
            out_l2_d = rd_a;
`endif
            out_l3_d     = pix_in;
            col_cnt_d    = cur_col;
            row_cnt_d    = cur_row;
            wr_sft_en_d  = 1'b1;
            win_valid_d  = (cur_row >= Two) && (cur_col >= Two);
            frame_done_d = (cur_col == ColLast) && (cur_row == RowLast);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icol_q       <= '0;
            irow_q       <= '0;
            out_l1_q     <= '0;
            out_l2_q     <= '0;
            out_l3_q     <= '0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            wr_sft_en_q  <= 1'b0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            icol_q       <= icol_d;
            irow_q       <= irow_d;
            out_l1_q     <= out_l1_d;
            out_l2_q     <= out_l2_d;
            out_l3_q     <= out_l3_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            wr_sft_en_q  <= wr_sft_en_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Read-modify-write: the row moves down one memory; a pixel arriving
    // together with rst is dropped and leaves the memories untouched.
    always_ff @(posedge clk) begin
        if (!rst && pix_valid) begin
            mem_b_q[col_idx] <= rd_a;
            mem_a_q[col_idx] <= pix_in;
        end
    end

    assign out_l1     = out_l1_q;
    assign out_l2     = out_l2_q;
    assign out_l3     = out_l3_q;
    assign wr_sft_en  = wr_sft_en_q;
    assign win_valid  = win_valid_q;
    assign col_cnt    = col_cnt_q;
    assign row_cnt    = row_cnt_q;
    assign frame_done = frame_done_q;

endmodule
